// File: rtl/tt_um_seq_divider.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit per clock.
// Tiny Tapeout user project using the standard tt_um pin set.
module tt_um_seq_divider (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned DW = 8;  // dividend / quotient width
    localparam int unsigned VW = 4;  // divisor / remainder width
    localparam int unsigned CW = 3;  // bit counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DW-1:0] dividend_q, dividend_d;
    logic [VW-1:0] divisor_q,  divisor_d;
    logic [CW-1:0] cnt_q,      cnt_d;
    logic [DW-1:0] quot_q,     quot_d;
    logic [VW-1:0] rem_q,      rem_d;
    logic          busy_q,     busy_d;
    logic          done_q,     done_d;
    logic          dbz_q,      dbz_d;

    logic [VW-1:0] divisor_in;
    logic          start;
    logic          sel;
    logic          accept;
    logic          div_zero_in;
    logic [VW:0]   partial;
    logic          fits;

    assign divisor_in  = uio_in[3:0];
    assign start       = uio_in[4];
    assign sel         = uio_in[5];
    assign accept      = start && (state_q != RUN);
    assign div_zero_in = (divisor_in == '0);

    // One restoring step: shift in the next dividend bit and trial-subtract with a 5-bit compare.
    assign partial = {rem_q, dividend_q[cnt_q]};
    assign fits    = (partial >= {1'b0, divisor_q});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = div_zero_in ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and status next values
    always_comb begin
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        cnt_d      = cnt_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        busy_d     = busy_q;
        done_d     = done_q;
        dbz_d      = dbz_q;

        if (accept) begin
            dividend_d = ui_in;
            divisor_d  = divisor_in;
            cnt_d      = CW'(DW - 1);
            if (div_zero_in) begin
                quot_d = '1;
                rem_d  = '1;
                dbz_d  = 1'b1;
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                quot_d = '0;
                rem_d  = '0;
                dbz_d  = 1'b0;
                busy_d = 1'b1;
                done_d = 1'b0;
            end
        end else if (state_q == RUN) begin
            if (fits) begin
                rem_d = VW'(partial - {1'b0, divisor_q});
            end else begin
                rem_d = partial[VW-1:0];
            end
            quot_d[cnt_q] = fits;
            cnt_d         = cnt_q - CW'(1);
            if (cnt_q == '0) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dividend_q <= '0;
            divisor_q  <= '0;
            cnt_q      <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            cnt_q      <= cnt_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
        end
    end

    // Pin mapping; sel only steers the result mux
    assign uo_out  = sel ? {3'b000, dbz_q, rem_q} : quot_q;
    assign uio_out = {done_q, busy_q, 6'b00_0000};
    assign uio_oe  = 8'b1100_0000;

    logic unused_pins;
    assign unused_pins = &{1'b0, ena, uio_in[7:6]};

endmodule

// File: tb/tb_tt_um_seq_divider.sv
// Randomized self-checking bench for tt_um_seq_divider against an arithmetic reference model.
module tb_tt_um_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tt_um_seq_divider dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [3:0] b, input logic st);
        ui_in  = a;
        uio_in = {2'($urandom), 1'b0, st, b};
    endtask

    // Reference model from the arithmetic definition of division
    task automatic expect_result(input logic [7:0] a, input logic [3:0] b,
                                 output logic [7:0] q, output logic [7:0] hi);
        if (b == 4'd0) begin
            q  = 8'hFF;
            hi = 8'h1F;
        end else begin
            q  = 8'(a / b);
            hi = 8'(a % b);
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] a, input logic [3:0] b);
        logic [7:0] q;
        logic [7:0] hi;
        expect_result(a, b, q, hi);
        uio_in[5] = 1'b0;
        #1 check({tag, "_quot"}, uo_out, q);
        uio_in[5] = 1'b1;
        #1 check({tag, "_rem"}, uo_out, hi);
        uio_in[5] = 1'b0;
        check({tag, "_status"}, uio_out, 8'h80);
        if (b != 4'd0) begin
            check({tag, "_invariant"}, 32'(q) * 32'(b) + 32'(hi), 32'(a));
        end
    endtask

    // Called just after a rising edge; the next edge captures (E0)
    task automatic run_div(input string tag, input logic [7:0] a, input logic [3:0] b,
                           input int hold);
        drive(a, b, 1'b1);
        @(posedge clk); #1;
        drive(8'($urandom), 4'($urandom), 1'b0);
        if (b == 4'd0) begin
            check({tag, "_dbz_1cyc"}, uio_out, 8'h80);
        end else begin
            for (int i = 0; i < 8; i++) begin
                check({tag, "_busy"}, uio_out, 8'h40);
                @(posedge clk); #1;
            end
        end
        check_result(tag, a, b);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_result({tag, "_hold"}, a, b);
        end
    endtask

    initial begin
        ena    = 1'b1;
        rst_n  = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #13;
        uio_in[5] = 1'b1;
        #1 check("reset_uo_sel1", uo_out, 8'h00);
        uio_in[5] = 1'b0;
        #1 check("reset_uo_sel0", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'hC0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_uio_out", uio_out, 8'h00);

        run_div("d200_7", 8'd200, 4'd7, 0);
        run_div("d255_1", 8'd255, 4'd1, 0);
        run_div("d255_15", 8'd255, 4'd15, 0);
        run_div("d5_9", 8'd5, 4'd9, 0);
        run_div("d0_3", 8'd0, 4'd3, 0);
        run_div("d100_0", 8'd100, 4'd0, 2);

        // Start held high through RUN with other operands on the pins
        @(posedge clk); #1;
        drive(8'd200, 4'd7, 1'b1);
        @(posedge clk); #1;
        drive(8'd13, 4'd3, 1'b1);
        for (int i = 0; i < 7; i++) begin
            check("held_busy", uio_out, 8'h40);
            @(posedge clk); #1;
        end
        check("held_busy_last", uio_out, 8'h40);
        @(posedge clk); #1;
        check_result("held_first", 8'd200, 4'd7);
        @(posedge clk); #1;
        check("held_restart", uio_out, 8'h40);
        drive(8'd0, 4'd0, 1'b0);
        repeat (7) @(posedge clk);
        @(posedge clk); #1;
        check_result("held_second", 8'd13, 4'd3);

        // Asynchronous reset in the middle of RUN
        drive(8'd17, 4'd4, 1'b1);
        @(posedge clk); #1;
        drive(8'd0, 4'd0, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        uio_in[5] = 1'b1;
        #1 check("midrun_rst_sel1", uo_out, 8'h00);
        uio_in[5] = 1'b0;
        #1 check("midrun_rst_sel0", uo_out, 8'h00);
        check("midrun_rst_uio", uio_out, 8'h00);
        check("midrun_rst_oe", uio_oe, 8'hC0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", uio_out, 8'h00);
        run_div("d17_4", 8'd17, 4'd4, 0);

        // Random sweep, divisor 0 included
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] a;
            logic [3:0] b;
            a = 8'($urandom);
            b = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
            run_div("rand", a, b, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
